// File: rtl/fetch_unit_if.sv
// Program-memory fetch bus of the instruction-fetch front end.
//   imem_addr : 8-bit instruction address, registered by the fetch unit
//   imem_req  : fetch request, held high until imem_ack completes it
//   imem_data : 16-bit instruction segment {opcode, operand} from memory
//   imem_ack  : imem_data is valid this cycle and the request completes
// master = fetch unit side, slave = program memory side.
interface fetch_unit_if;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_data;
    logic        imem_ack;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_data,
        input  imem_ack
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_data,
        output imem_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end of the 3-stage pipelined processor.
// Owns the program counter, fetches 16-bit segments over the bus
// req/ack handshake and hands each one, with its next-PC, to stage 1.
// Control-transfer opcodes are pre-decoded; after one is delivered the
// unit emits NOP bubbles until stage 3 either redirects the PC (l_pc with
// the s11/s10 mux select) or the bubble budget runs out (fall-through).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (master)          imem_addr/imem_req out, imem_data/imem_ack in
//   stall                 blocks issue of a new request (never aborts one)
//   l_pc, s11, s10        PC load strobe and target select from stage 3
//   od_in, dm_in, r0_in   candidate targets: operand, popped return, R0
//   segment               instruction to stage 1, 16'h0000 when no fetch
//   pc_out                address of delivered instruction + 1
//   seg_valid             segment holds a real fetched instruction
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         BR_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus,
    input  logic        stall,
    input  logic        l_pc,
    input  logic        s11,
    input  logic        s10,
    input  logic [7:0]  od_in,
    input  logic [7:0]  dm_in,
    input  logic [7:0]  r0_in,
    output logic [15:0] segment,
    output logic [7:0]  pc_out,
    output logic        seg_valid
);

    localparam int CNT_W = $clog2(BR_WAIT + 2);

    typedef enum logic [1:0] {IDLE, REQ, BRWAIT} state_t;

    state_t             state, state_n;
    logic [7:0]         pc, pc_n, addr_n, target;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               out, out_n;     // request raised and not yet acked
    logic               drop, drop_n;   // outstanding ack must be discarded
    logic               hold;           // keep imem_addr on the open request
    logic               req, acc;
    logic [15:0]        seg_p0, seg_n;
    logic               vld_p0, vld_n;
    logic [7:0]         npc_p0, npc_n;

    // Opcodes that transfer control: 03..07, 08..0F, 28..2F, 30..3F, 48..4F.
    function automatic logic is_ctl(input logic [7:0] op);
        logic hit;
        hit = ((op[7:3] == 5'b00000) && (op[2:0] >= 3'd3)) ||
              (op[7:3] == 5'b00001) ||
              (op[7:3] == 5'b00101) ||
              (op[7:4] == 4'b0011)  ||
              (op[7:3] == 5'b01001);
        return hit;
    endfunction

    function automatic logic [7:0] pc_target(input logic [1:0] sel,
                                             input logic [7:0] cur,
                                             input logic [7:0] od,
                                             input logic [7:0] dm,
                                             input logic [7:0] r0);
        logic [7:0] t;
        case (sel)
            2'b01:   t = od;
            2'b10:   t = dm;
            2'b11:   t = r0;
            default: t = cur;
        endcase
        return t;
    endfunction

    // Once raised, a request stays up until acked, regardless of stall.
    assign req          = (state == REQ) && (out || !stall);
    assign acc          = req && bus.imem_ack;
    assign bus.imem_req = req;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        drop_n  = drop;
        out_n   = 1'b0;
        hold    = 1'b0;
        seg_n   = 16'h0000;
        vld_n   = 1'b0;
        npc_n   = npc_p0;
        target  = pc_target({s11, s10}, pc, od_in, dm_in, r0_in);
        case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                out_n = req && !bus.imem_ack;
                if (l_pc) begin
                    // Redirect: an ack this cycle is thrown away; an open
                    // request is finished first and its data dropped.
                    pc_n = target;
                    if (acc) begin
                        drop_n = 1'b0;
                    end else if (req) begin
                        drop_n = 1'b1;
                        hold   = 1'b1;
                    end
                end else if (acc) begin
                    if (drop) begin
                        drop_n = 1'b0;
                    end else begin
                        seg_n = bus.imem_data;
                        vld_n = 1'b1;
                        pc_n  = pc + 8'd1;
                        npc_n = pc + 8'd1;
                        if (is_ctl(bus.imem_data[15:8])) begin
                            state_n = BRWAIT;
                            cnt_n   = CNT_W'(BR_WAIT);
                        end
                    end
                end else if (req) begin
                    hold = 1'b1;
                end
            end
            BRWAIT: begin
                if (l_pc) begin
                    pc_n    = target;
                    state_n = REQ;
                    cnt_n   = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    // Branch not taken: resume at the already-advanced pc.
                    state_n = REQ;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        addr_n = hold ? bus.imem_addr : pc_n;
    end

    // Stage boundary: fetch -> stage 1 (segment, npc and valid registered together)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            bus.imem_addr <= RESET_PC;
            cnt           <= '0;
            out           <= 1'b0;
            drop          <= 1'b0;
            seg_p0        <= 16'h0000;
            vld_p0        <= 1'b0;
            npc_p0        <= 8'h00;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            bus.imem_addr <= addr_n;
            cnt           <= cnt_n;
            out           <= out_n;
            drop          <= drop_n;
            seg_p0        <= seg_n;
            vld_p0        <= vld_n;
            npc_p0        <= npc_n;
        end
    end

    assign segment   = seg_p0;
    assign seg_valid = vld_p0;
    assign pc_out    = npc_p0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the 3-stage pipelined processor.
- Owns the program counter and fetches 16-bit instruction segments ({opcode[15:8], operand[7:0]}) from program memory over a req/ack handshake.
- Presents each segment, with its next-PC value, to the first control pipeline stage.
- Pre-decodes control-transfer opcodes and issues NOP bubbles until stage 3 resolves the branch, then consumes that stage's L_PC and PC-mux selects (S11/S10) to redirect fetch.

Parameters:
RESET_PC, 8'h00, PC value loaded at reset
BR_WAIT, 3, bubble cycles after a control-transfer instruction before fall-through fetch resumes (pipeline depth to stage 3)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  8  program memory address (registered)
imem_req  output  1  fetch request, held until imem_ack
imem_data  input  16  instruction segment returned by memory
imem_ack  input  1  imem_data valid this cycle; completes the request
stall  input  1  blocks issue of a new request
l_pc  input  1  PC load strobe from stage 3
s11  input  1  PC mux select bit 1
s10  input  1  PC mux select bit 0
od_in  input  8  direct target (stage-3 operand register)
dm_in  input  8  return address popped from data memory
r0_in  input  8  absolute target from R0
segment  output  16  instruction to stage 1; 16'h0000 (NOP) when no valid fetch
pc_out  output  8  address of delivered instruction + 1 (NPC for calls)
seg_valid  output  1  segment holds a real fetched instruction this cycle

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, segment=16'h0000, pc_out=8'h00, seg_valid=0, drop=0, state=IDLE, bubble counter=0.
- FSM states: IDLE, REQ, BRWAIT.
- IDLE: lasts one cycle after reset release, then goes to REQ.
- REQ:
  - imem_req=1 with imem_addr=pc, unless stall=1 and no request is outstanding.
  - A raised request is never withdrawn before ack; stall does not abort it.
- On imem_ack in REQ (no redirect, drop=0):
  - Next edge: segment<=imem_data, seg_valid<=1, pc_out<=pc+1, pc<=pc+1 (8-bit wrap, FF->00).
  - imem_addr follows the new pc. A back-to-back request may stay high.
- Every cycle without a delivered instruction: segment<=16'h0000, seg_valid<=0. Stage 1 therefore sees NOPs, never a repeated instruction.
- Control-transfer pre-decode on imem_data[15:8]:
  - Matching opcodes: 0000_0_011 through 0000_0_111, 0000_1_xxx, 0010_1_xxx, 0011_x_xxx, 0100_1_xxx.
  - On delivery of a match: state<=BRWAIT, counter<=BR_WAIT, imem_req<=0.
- BRWAIT:
  - No requests issued; bubbles output; counter decrements each cycle.
  - Counter reaches 0 without l_pc: return to REQ at pc (fall-through, already incremented). This is the not-taken conditional case.
- l_pc=1 in any state except IDLE: pc<=target, state<=REQ. Target by {s11,s10}:
  - 00: pc (reload, no change)
  - 01: od_in
  - 10: dm_in
  - 11: r0_in
- Redirect priority and outstanding requests:
  - l_pc and counter expiry in the same cycle: l_pc wins.
  - l_pc in REQ with a request outstanding and no ack: set drop. Req stays high until ack; that ack's data is discarded as a bubble and drop clears. Next edge: new request at target.
  - l_pc and imem_ack in the same cycle: the acked data is discarded and pc<=target.
- Latency: from ack to segment valid is 1 cycle. Minimum redirect to first target request is 1 cycle.
- Reset asserted mid-transaction: immediate return to reset values; any later ack is ignored until state=REQ.

Test Plan:
- Sequential fetch: zero-wait memory returns 16'h4102, 16'h8803, 16'h0000 at 00,01,02 -> segment shows them on consecutive cycles with seg_valid=1 and pc_out=01,02,03.
- Handshake wait: ack delayed 3 cycles at addr 05 -> imem_req and imem_addr=05 held stable; 3 NOP bubbles with seg_valid=0; then segment=imem_data, pc_out=06.
- Taken jump: JUD (16'h0340) at 10, then l_pc=1 with {s11,s10}=01, od_in=8'h40 on cycle 3 of BRWAIT -> exactly 3 NOP cycles, then next request at imem_addr=40.
- Not-taken conditional: JCD (16'h0820) at 20, l_pc never asserted -> BR_WAIT bubbles, then fetch resumes at 21.
- Return and wrap: fetch at FF delivers pc_out=00 and next addr=00. Then RTU with l_pc, {s11,s10}=10, dm_in=8'h33 -> fetch at 33. l_pc with ack in the same cycle -> acked data dropped, no seg_valid.
- Stall/reset: stall=1 during an outstanding request -> ack still delivered, no new request while stall=1. rst_n low mid-request -> imem_req=0 and segment=0 immediately, fetch restarts at RESET_PC.
